// File: rtl/hex_display_scanner.sv
// Time-multiplexed scanner for a common-anode 7-segment display: latches a value,
// walks the digits with a dead time per slot and swaps the value only at frame boundaries.
module hex_display_scanner #(
    parameter int NUM_DIGITS       = 8,
    parameter int REFRESH_DIV      = 50000,
    parameter int DEAD_CYCLES      = 16,
    parameter int ANODE_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable_i,
    input  logic [4*NUM_DIGITS-1:0] value_i,
    input  logic                    load_i,
    input  logic                    blank_lz_i,
    output logic [3:0]              hex_o,
    output logic                    blank_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic [2:0]              digit_idx_o,
    output logic                    frame_done_o
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] P_DEAD = PW'(DEAD_CYCLES);
    localparam logic [2:0] D_LAST = 3'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{ANODE_ACTIVE_LOW != 0}};

    logic [PW-1:0]           prescaler;
    logic [2:0]              digit_idx;
    logic [4*NUM_DIGITS-1:0] active_val;
    logic [4*NUM_DIGITS-1:0] pending_val;
    logic                    pending_vld;

    logic                  tick;
    logic                  wrap;
    logic                  nz;
    logic [7:0]            lz;
    logic [7:0]            sel8;
    logic [NUM_DIGITS-1:0] sel;
    logic [3:0]            hex_nxt;
    logic                  lit;

    always_comb begin
        tick = enable_i && (prescaler == P_LAST);
        wrap = tick && (digit_idx == D_LAST);
        // Walk from the most significant digit down; a digit is blankable
        // only while every nibble at or above it is zero.
        nz = 1'b0;
        lz = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            nz    = nz | (active_val[4*k +: 4] != 4'd0);
            lz[k] = blank_lz_i && !nz && (k != 0);
        end
        sel8    = 8'd1 << digit_idx;
        sel     = sel8[NUM_DIGITS-1:0];
        hex_nxt = 4'(active_val >> {digit_idx, 2'b00});
        lit     = enable_i && (prescaler >= P_DEAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
            digit_idx <= '0;
        end else if (!enable_i) begin
            prescaler <= '0;
            digit_idx <= '0;
        end else if (tick) begin
            prescaler <= '0;
            digit_idx <= wrap ? 3'd0 : digit_idx + 3'd1;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // A load on the boundary cycle bypasses pending so the fresh value wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_val  <= '0;
            pending_val <= '0;
            pending_vld <= 1'b0;
        end else begin
            if (load_i) begin
                pending_val <= value_i;
                pending_vld <= 1'b1;
            end
            if (wrap) begin
                if (load_i) begin
                    active_val  <= value_i;
                    pending_vld <= 1'b0;
                end else if (pending_vld) begin
                    active_val  <= pending_val;
                    pending_vld <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex_o        <= 4'd0;
            blank_o      <= 1'b1;
            an_o         <= AN_OFF;
            digit_idx_o  <= 3'd0;
            frame_done_o <= 1'b0;
        end else begin
            hex_o        <= hex_nxt;
            blank_o      <= !lit || lz[digit_idx];
            an_o         <= lit ? (sel ^ AN_OFF) : AN_OFF;
            digit_idx_o  <= digit_idx;
            frame_done_o <= wrap;
        end
    end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed bench for hex_display_scanner with 4 digits, 4-cycle slots and 1 dead cycle.
module tb_hex_display_scanner;

    logic        clk;
    logic        rst_n;
    logic        enable_i;
    logic [15:0] value_i;
    logic        load_i;
    logic        blank_lz_i;
    logic [3:0]  hex_o;
    logic        blank_o;
    logic [3:0]  an_o;
    logic [2:0]  digit_idx_o;
    logic        frame_done_o;

    int errors = 0;
    int checks = 0;
    int c = 0;

    hex_display_scanner #(
        .NUM_DIGITS(4), .REFRESH_DIV(4), .DEAD_CYCLES(1), .ANODE_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .value_i(value_i),
        .load_i(load_i), .blank_lz_i(blank_lz_i), .hex_o(hex_o), .blank_o(blank_o),
        .an_o(an_o), .digit_idx_o(digit_idx_o), .frame_done_o(frame_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s c=%0d observed=%0h expected=%0h", tag, c, obs, exp);
        end
    endtask

    // Checks cycles c..c_end-1 of a running scan showing value v.
    task automatic run_to(input int c_end, input logic [15:0] v, input logic lz);
        int slot, ph;
        logic [15:0] upper;
        logic [3:0] e_an;
        logic e_blank;
        while (c < c_end) begin
            @(negedge clk);
            slot  = (c / 4) % 4;
            ph    = c % 4;
            upper = v >> (4 * slot);
            e_an  = (ph == 0) ? 4'b1111 : ~(4'b0001 << slot);
            e_blank = (ph == 0) || (lz && slot != 0 && upper == 16'h0);
            chk("an", 32'(an_o), 32'(e_an));
            chk("blank", 32'(blank_o), 32'(e_blank));
            chk("hex", 32'(hex_o), 32'(upper[3:0]));
            chk("idx", 32'(digit_idx_o), 32'(slot));
            chk("frame_done", 32'(frame_done_o), 32'((c % 16) == 15));
            c++;
        end
    endtask

    task automatic pulse_load(input logic [15:0] v, input int c_end, input logic [15:0] shown,
                              input logic lz);
        load_i  = 1'b1;
        value_i = v;
        run_to(c_end, shown, lz);
        load_i  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; enable_i = 1'b0; value_i = 16'h0; load_i = 1'b0; blank_lz_i = 1'b0;
        #12;
        @(negedge clk);
        chk("rst_an", 32'(an_o), 32'hF);
        chk("rst_blank", 32'(blank_o), 32'h1);
        chk("rst_hex", 32'(hex_o), 32'h0);
        chk("rst_fd", 32'(frame_done_o), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        enable_i = 1'b1;

        // idle frames, then a mid-frame load that waits for the boundary
        run_to(21, 16'h0, 1'b0);
        pulse_load(16'hA3C5, 22, 16'h0, 1'b0);
        run_to(32, 16'h0, 1'b0);
        run_to(37, 16'hA3C5, 1'b0);
        pulse_load(16'h1111, 38, 16'hA3C5, 1'b0);
        run_to(41, 16'hA3C5, 1'b0);
        pulse_load(16'h2222, 42, 16'hA3C5, 1'b0);
        run_to(48, 16'hA3C5, 1'b0);

        // leading-zero blanking
        blank_lz_i = 1'b1;
        run_to(50, 16'h2222, 1'b1);
        pulse_load(16'h0040, 51, 16'h2222, 1'b1);
        run_to(64, 16'h2222, 1'b1);
        run_to(70, 16'h0040, 1'b1);
        pulse_load(16'h0000, 71, 16'h0040, 1'b1);
        run_to(80, 16'h0040, 1'b1);

        // older pending overridden by a load on the wrap tick
        run_to(85, 16'h0000, 1'b1);
        pulse_load(16'h1234, 86, 16'h0000, 1'b1);
        run_to(95, 16'h0000, 1'b1);
        pulse_load(16'h0B07, 96, 16'h0000, 1'b1);
        run_to(112, 16'h0B07, 1'b1);

        // disable: anodes off, loads still go to pending
        enable_i = 1'b0;
        load_i = 1'b1;
        value_i = 16'h5555;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            load_i = 1'b0;
            chk("dis_an", 32'(an_o), 32'hF);
            chk("dis_blank", 32'(blank_o), 32'h1);
            chk("dis_idx", 32'(digit_idx_o), 32'h0);
            chk("dis_fd", 32'(frame_done_o), 32'h0);
        end

        // short async reset between edges discards pending and active
        enable_i = 1'b1;
        blank_lz_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_an", 32'(an_o), 32'hF);
        chk("arst_blank", 32'(blank_o), 32'h1);
        chk("arst_hex", 32'(hex_o), 32'h0);
        #1 rst_n = 1'b1;
        c = 0;
        run_to(32, 16'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
